// File: rtl/uart_tx_frame_sequencer_pkg.sv
// Shared frame definitions for the UART game-state link (TX and RX ends).
// `TX_SEQ_NUM_EN adds a sequence byte after the header.
package uart_frame_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int PAY_LEN = 10;

`ifdef TX_SEQ_NUM_EN
    localparam int FRAME_LEN = 13;
    localparam int PAY_OFS   = 2;
`else
    localparam int FRAME_LEN = 12;
    localparam int PAY_OFS   = 1;
`endif

    localparam int LAST_IDX = FRAME_LEN - 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } tx_state_t;

    localparam int FLAG_TANK_HIT = 7;
    localparam int FLAG_OBS_HIT  = 6;
    localparam int FLAG_TDIR_LSB = 4;
    localparam int FLAG_EDIR_LSB = 1;

    typedef struct packed {
        logic [9:0] tank_x;
        logic [9:0] tank_y;
        logic [9:0] bullet_x;
        logic [9:0] bullet_y;
        logic [7:0] flags;
        logic [7:0] hp;
`ifdef TX_SEQ_NUM_EN
        logic [7:0] seq;
`endif
    } snap_t;

    function automatic logic [7:0] pack_flags(
        input logic       tank_hit,
        input logic       obs_hit,
        input logic [1:0] tank_dir,
        input logic [2:0] enemy_dir
    );
        logic [7:0] f;
        f = '0;
        f[FLAG_TANK_HIT]        = tank_hit;
        f[FLAG_OBS_HIT]         = obs_hit;
        f[FLAG_TDIR_LSB +: 2]   = tank_dir;
        f[FLAG_EDIR_LSB +: 3]   = enemy_dir;
        return f;
    endfunction

    function automatic logic [PAY_LEN-1:0][7:0] payload(
        input snap_t s
    );
        logic [PAY_LEN-1:0][7:0] p;
        p[0] = {6'b0, s.tank_x[9:8]};
        p[1] = s.tank_x[7:0];
        p[2] = {6'b0, s.tank_y[9:8]};
        p[3] = s.tank_y[7:0];
        p[4] = {6'b0, s.bullet_x[9:8]};
        p[5] = s.bullet_x[7:0];
        p[6] = {6'b0, s.bullet_y[9:8]};
        p[7] = s.bullet_y[7:0];
        p[8] = s.flags;
        p[9] = s.hp;
        return p;
    endfunction

    // Header is excluded; the sequence byte (when present) is covered.
    function automatic logic [7:0] checksum(input snap_t s);
        logic [PAY_LEN-1:0][7:0] p;
        logic [7:0] c;
        p = payload(s);
`ifdef TX_SEQ_NUM_EN
        c = s.seq;
`else
        c = '0;
`endif
        for (int k = 0; k < PAY_LEN; k++) begin
            c = c + p[k];
        end
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(
        input snap_t      s,
        input logic [7:0] hdr,
        input logic [3:0] idx
    );
        logic [PAY_LEN-1:0][7:0] p;
        logic [3:0] k;
        p = payload(s);
        k = idx - 4'(PAY_OFS);
        if (idx == 4'd0) return hdr;
`ifdef TX_SEQ_NUM_EN
        if (idx == 4'd1) return s.seq;
`endif
        if (k < 4'(PAY_LEN)) return p[k];
        return checksum(s);
    endfunction

endpackage

// File: rtl/uart_tx_frame_sequencer_if.sv
// Byte handshake between the frame sequencer and uart_tx.
// master = sequencer side, slave = uart_tx side.
interface uart_tx_frame_sequencer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done_tick;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx_frame_sequencer_timer.sv
// Free-running mod-FRAME_PERIOD counter; tick is high in the wrap cycle.
module tx_frame_timer #(
    parameter int FRAME_PERIOD = 500000,
    parameter int PERIOD_BITS  = 19
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    logic [PERIOD_BITS-1:0] cnt;

    assign tick = (cnt == PERIOD_BITS'(FRAME_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_frame_sequencer.sv
// Snapshots game state and streams it to uart_tx as a checksummed frame.
// Optional `TX_SEQ_NUM_EN inserts a rolling sequence byte after the header.
module uart_tx_frame_sequencer
    import uart_frame_pkg::*;
#(
    parameter int         FRAME_PERIOD = 500000,
    parameter int         PERIOD_BITS  = 19,
    parameter logic [7:0] HEADER_BYTE  = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] tank_x_in,
    input  logic [9:0] tank_y_in,
    input  logic [9:0] bullet_x_in,
    input  logic [9:0] bullet_y_in,
    input  logic [2:0] enemy_dir_in,
    input  logic       tank_hit_in,
    input  logic       obstacle_hit_in,
    input  logic [1:0] tank_dir_in,
    input  logic [7:0] hp_in,
    input  logic       send_now,
    uart_tx_frame_sequencer_if.master tx,
    output logic       busy,
    output logic       frame_done
);
    logic       tick;
    logic       req;
    logic       pending;
    logic       load;
    logic       done_c;
    logic       busy_c;
    tx_state_t  state;
    tx_state_t  state_nx;
    logic [3:0] idx;
    logic [3:0] idx_nx;
    logic [7:0] data_q;
    snap_t      snap;
    snap_t      live;
`ifdef TX_SEQ_NUM_EN
    logic [7:0] seq;
`endif

    tx_frame_timer #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .PERIOD_BITS  (PERIOD_BITS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign req = tick | send_now;

    always_comb begin
        live          = '0;
        live.tank_x   = tank_x_in;
        live.tank_y   = tank_y_in;
        live.bullet_x = bullet_x_in;
        live.bullet_y = bullet_y_in;
        live.flags    = pack_flags(tank_hit_in, obstacle_hit_in,
                                   tank_dir_in, enemy_dir_in);
        live.hp       = hp_in;
`ifdef TX_SEQ_NUM_EN
        live.seq      = seq;
`endif
    end

    // busy drops in the cycle frame_done pulses, not one later.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        load     = 1'b0;
        done_c   = 1'b0;
        busy_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    load     = 1'b1;
                    idx_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                busy_c   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                busy_c = 1'b1;
                if (tx.tx_done_tick) begin
                    if (idx < 4'(LAST_IDX)) begin
                        idx_nx   = idx + 1'b1;
                        state_nx = START;
                    end else begin
                        done_c   = 1'b1;
                        busy_c   = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            data_q  <= '0;
            snap    <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (load) begin
                snap    <= live;
                pending <= 1'b0;
            end else if (req) begin
                pending <= 1'b1;
            end
            if (state_nx == START) begin
                data_q <= frame_byte(load ? live : snap,
                                     HEADER_BYTE, idx_nx);
            end
        end
    end

`ifdef TX_SEQ_NUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            seq <= '0;
        end else if (done_c) begin
            seq <= seq + 1'b1;
        end
    end
`endif

    assign tx.tx_start = (state == START);
    assign tx.tx_data  = data_q;
    assign busy        = busy_c;
    assign frame_done  = done_c;

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Randomized bench for uart_tx_frame_sequencer with a frame-level model.
module tb_uart_tx_frame_sequencer;

  localparam int P  = 3000;
  localparam int PB = 12;
`ifdef TX_SEQ_NUM_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tank_x = '0;
  logic [9:0] tank_y = '0;
  logic [9:0] bullet_x = '0;
  logic [9:0] bullet_y = '0;
  logic [2:0] enemy_dir = '0;
  logic       tank_hit = 1'b0;
  logic       obstacle_hit = 1'b0;
  logic [1:0] tank_dir = '0;
  logic [7:0] hp = '0;
  logic       send_now = 1'b0;
  logic       busy;
  logic       frame_done;

  uart_tx_frame_sequencer_if txi ();

  uart_tx_frame_sequencer #(
    .FRAME_PERIOD (P),
    .PERIOD_BITS  (PB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tank_x_in       (tank_x),
    .tank_y_in       (tank_y),
    .bullet_x_in     (bullet_x),
    .bullet_y_in     (bullet_y),
    .enemy_dir_in    (enemy_dir),
    .tank_hit_in     (tank_hit),
    .obstacle_hit_in (obstacle_hit),
    .tank_dir_in     (tank_dir),
    .hp_in           (hp),
    .send_now        (send_now),
    .tx              (txi.master),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame-level reference state
  int         cyc = 0;
  int         tmr = 0;
  int         uart_cnt = 0;
  bit         stray_req = 0;
  bit         m_active = 0;
  bit         m_pend = 0;
  bit         m_started = 0;
  int         m_byte = 0;
  int         m_due = 0;
  int         m_first = 0;
  int         m_start_cyc = 0;
  int         m_seq = 0;
  int         dut_frames = 0;
  logic [7:0] exp_b [13];
  logic [7:0] obs_q [$];

  function automatic void build_frame();
    int v [10];
    int k;
    int s;
    v[0] = tank_x / 256;
    v[1] = tank_x % 256;
    v[2] = tank_y / 256;
    v[3] = tank_y % 256;
    v[4] = bullet_x / 256;
    v[5] = bullet_x % 256;
    v[6] = bullet_y / 256;
    v[7] = bullet_y % 256;
    v[8] = tank_hit * 128 + obstacle_hit * 64
         + tank_dir * 16 + enemy_dir * 2;
    v[9] = hp;
    exp_b[0] = 8'hA5;
    k = 1;
    s = 0;
`ifdef TX_SEQ_NUM_EN
    exp_b[1] = 8'(m_seq % 256);
    s = m_seq % 256;
    k = 2;
`endif
    for (int i = 0; i < 10; i++) begin
      exp_b[k + i] = 8'(v[i]);
      s += v[i];
    end
    exp_b[k + 10] = 8'(s % 256);
  endfunction

  // uart_tx stand-in: done tick 20 cycles after each start
  initial forever begin
    @(posedge clk);
    #1;
    txi.tx_done_tick = 1'b0;
    if (stray_req) begin
      txi.tx_done_tick = 1'b1;
      stray_req = 0;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) txi.tx_done_tick = 1'b1;
    end
  end

  initial forever begin
    bit was_active;
    bit waiting;
    bit exp_start;
    bit exp_done;
    bit exp_busy;
    bit last;
    @(negedge clk);
    cyc++;
    if (reset) begin
      m_active = 0;
      m_pend = 0;
      m_started = 0;
      uart_cnt = 0;
      tmr = 0;
      m_seq = 0;
      continue;
    end
    was_active = m_active;
    waiting = m_active && m_started && cyc > m_start_cyc;
    exp_start = m_active && !m_started && cyc == m_due;
    last = (m_byte == NB - 1);
    exp_done = waiting && txi.tx_done_tick && last;
    exp_busy = m_active && cyc >= m_first && !exp_done;
    if (txi.tx_start || exp_start)
      chk("tx_start", txi.tx_start, exp_start);
    if (txi.tx_start) begin
      uart_cnt = 20;
      obs_q.push_back(txi.tx_data);
    end
    if (exp_start)
      chk("tx_data", txi.tx_data, exp_b[m_byte]);
    if (waiting)
      chk("tx_hold", txi.tx_data, exp_b[m_byte]);
    if (frame_done || exp_done)
      chk("frame_done", frame_done, exp_done);
    if (frame_done) dut_frames++;
    chk("busy", busy, exp_busy);
    if (exp_start) begin
      m_started = 1;
      m_start_cyc = cyc;
    end else if (waiting && txi.tx_done_tick) begin
      if (last) begin
        m_active = 0;
        m_seq++;
      end else begin
        m_byte++;
        m_started = 0;
        m_due = cyc + 1;
      end
    end
    if (!was_active && m_pend) begin
      m_pend = 0;
      m_active = 1;
      m_byte = 0;
      m_started = 0;
      m_due = cyc + 1;
      m_first = cyc + 1;
      build_frame();
    end else if (send_now || tmr == P - 1) begin
      m_pend = 1;
    end
    tmr = (tmr == P - 1) ? 0 : tmr + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_send();
    send_now = 1'b1;
    step();
    send_now = 1'b0;
  endtask

  task automatic rand_inputs();
    tank_x = 10'($urandom);
    tank_y = 10'($urandom);
    bullet_x = 10'($urandom);
    bullet_y = 10'($urandom);
    enemy_dir = 3'($urandom);
    tank_hit = 1'($urandom);
    obstacle_hit = 1'($urandom);
    tank_dir = 2'($urandom);
    hp = 8'($urandom);
  endtask

  task automatic set_golden();
    tank_x = 10'h155;
    tank_y = 10'h0C8;
    bullet_x = 10'h3FF;
    bullet_y = 10'h000;
    tank_hit = 1'b1;
    obstacle_hit = 1'b0;
    tank_dir = 2'b10;
    enemy_dir = 3'b101;
    hp = 8'h64;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int i;
    for (i = 0; i < max; i++) begin
      step();
      if (!m_active && !m_pend && !busy) break;
    end
    if (i == max) chk(tag, 0, 1);
  endtask

  task automatic wait_bytes(input int n, input int max,
                            input string tag);
    int i;
    for (i = 0; i < max; i++) begin
      if (obs_q.size() >= n) break;
      step();
    end
    if (i == max) chk(tag, 0, 1);
  endtask

  task automatic cmp_golden(input string tag,
                            input logic [7:0] g [13]);
    chk({tag, "_len"}, obs_q.size(), NB);
    for (int k = 0; k < NB; k++)
      chk(tag, (k < obs_q.size()) ? obs_q[k] : 8'hxx, g[k]);
  endtask

  initial begin
    logic [7:0] g [13];
    int f0;
    int i;
`ifdef TX_SEQ_NUM_EN
    g = '{8'hA5, 8'h00, 8'h01, 8'h55, 8'h00, 8'hC8, 8'h03,
          8'hFF, 8'h00, 8'h00, 8'hAA, 8'h64, 8'h2E};
`else
    g = '{8'hA5, 8'h01, 8'h55, 8'h00, 8'hC8, 8'h03, 8'hFF,
          8'h00, 8'h00, 8'hAA, 8'h64, 8'h2E, 8'h00};
`endif
    txi.tx_done_tick = 1'b0;
    step(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", txi.tx_start, 0);
    chk("rst_tx_data", txi.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);

    // golden frame
    set_golden();
    step();
    obs_q.delete();
    pulse_send();
    wait_idle(600, "s1_timeout");
    chk("s1_frames", dut_frames, 1);
    cmp_golden("s1_byte", g);

    // inputs change mid-frame
`ifdef TX_SEQ_NUM_EN
    g[1] = 8'h01;
    g[12] = 8'h2F;
`endif
    obs_q.delete();
    pulse_send();
    wait_bytes(4, 200, "s2_bytes_timeout");
    rand_inputs();
    wait_idle(600, "s2_timeout");
    cmp_golden("s2_byte", g);

    // three requests while busy collapse into one frame
    f0 = dut_frames;
    pulse_send();
    wait_bytes(1, 10, "s3_start_timeout");
    for (i = 0; i < 3; i++) begin
      step(30);
      rand_inputs();
      pulse_send();
    end
    wait_idle(1200, "s3_timeout");
    chk("s3_frames", dut_frames - f0, 2);

    // reset during byte 5 wait
    f0 = dut_frames;
    obs_q.delete();
    pulse_send();
    wait_bytes(6, 400, "s4_bytes_timeout");
    step(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("s4_busy", busy, 0);
    chk("s4_tx_start", txi.tx_start, 0);
    chk("s4_frame_done", frame_done, 0);
    step();
    chk("s4_frames", dut_frames - f0, 0);
    obs_q.delete();
    pulse_send();
    wait_idle(600, "s4_timeout");
    chk("s4_restart_hdr", obs_q.size() > 0 ? obs_q[0] : 8'h00, 8'hA5);
    chk("s4_restart_len", obs_q.size(), NB);

    // done tick while idle is ignored
    f0 = dut_frames;
    stray_req = 1;
    step(30);
    chk("stray_frames", dut_frames - f0, 0);
    chk("stray_busy", busy, 0);

    // timer-driven frame with no send_now
    f0 = dut_frames;
    for (i = 0; i < P + 400; i++) begin
      step();
      if (dut_frames != f0) break;
    end
    chk("timer_frame", dut_frames - f0, 1);

    // random traffic with input churn
    for (int it = 0; it < 20; it++) begin
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(7) == 0) rand_inputs();
        send_now = ($urandom_range(59) == 0);
        step();
      end
    end
    send_now = 1'b0;
    wait_idle(1500, "rand_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
